// File: rtl/fetch_queue.sv
// Circular-buffer instruction queue between fetch and decode, with valid/ready on both sides.
// 1-cycle push-to-head latency; refuses pushes when full and drops all contents on flush.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     prv_valid,
  output logic                     prv_ready,
  input  logic [WIDTH-1:0]         prv_data,
  output logic                     nxt_valid,
  input  logic                     nxt_ready,
  output logic [WIDTH-1:0]         nxt_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    count_q, count_d;
  logic             full, empty, push, pop;

  // Wrap bit in the MSB distinguishes full from empty when the indices match.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  // No pop-through when full: prv_ready ignores a simultaneous pop.
  assign push = prv_valid && !full && !flush;
  assign pop  = !empty && nxt_ready && !flush;

  assign prv_ready   = !full;
  assign nxt_valid   = !empty;
  assign nxt_data    = mem_q[head_q[AW-1:0]];
  assign count       = count_q;
  assign almost_full = (count_q >= PW'(DEPTH - 1));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop)      count_d = count_q + PW'(1);
      else if (pop && !push) count_d = count_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q[AW-1:0]] <= prv_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboarded bench for fetch_queue: directed scenarios followed by random traffic.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             prv_valid = 1'b0;
  logic             prv_ready;
  logic [WIDTH-1:0] prv_data = '0;
  logic             nxt_valid;
  logic             nxt_ready = 1'b0;
  logic [WIDTH-1:0] nxt_data;
  logic [3:0]       count;
  logic             almost_full;

  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               mcount = 0;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .prv_valid(prv_valid), .prv_ready(prv_ready), .prv_data(prv_data),
    .nxt_valid(nxt_valid), .nxt_ready(nxt_ready), .nxt_data(nxt_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Reference model: an ideal queue of capacity DEPTH, evaluated at each active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mcount = 0;
    end else if (flush) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      automatic bit do_pop  = (mcount > 0) && nxt_ready;
      automatic bit do_push = (mcount < DEPTH) && prv_valid;
      if (do_push) exp_q.push_back(prv_data);
      mcount = mcount + int'(do_push) - int'(do_pop);
    end
  end

  // Monitor: status checks every cycle, data checked on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(count), 64'(mcount));
      chk("nxt_valid", 64'(nxt_valid), 64'(mcount != 0));
      chk("prv_ready", 64'(prv_ready), 64'(mcount < DEPTH));
      chk("almost_full", 64'(almost_full), 64'(mcount >= DEPTH - 1));
      if (nxt_valid && nxt_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pop_data: got %0h expected no entry at %0t", nxt_data, $time);
        end else begin
          chk("nxt_data", nxt_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    prv_valid = v;
    prv_data  = d;
    nxt_ready = r;
    flush     = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle state
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_nxt_data", nxt_data, 64'h0);

    // Fill 0x10..0x17 then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);

    // Full queue refuses a push even while popping; retried next cycle
    for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h20 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'hAA, 1'b1, 1'b0);
    step(1'b1, 64'hAA, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

    // Concurrent streaming, pointers wrap twice
    for (int i = 0; i < 20; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);

    // Flush at count 5 with push and pop requested
    for (int i = 0; i < 5; i++) step(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'hEE, 1'b1, 1'b1);
    step(1'b1, 64'h77, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset between edges at count 4
    for (int i = 0; i < 4; i++) step(1'b1, 64'h40 + 64'(i), 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_nxt_valid", 64'(nxt_valid), 64'h0);
    chk("arst_prv_ready", 64'(prv_ready), 64'h1);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_almost_full", 64'(almost_full), 64'h0);
    chk("arst_nxt_data", nxt_data, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 64'h55, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_arst_data", nxt_data, 64'h55);
    chk("post_arst_count", 64'(count), 64'h1);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("final_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Circular-buffer instruction queue between the fetch-stage pipeline register and decode/rename.
- Absorbs fetch bursts and decode stalls using valid/ready handshakes on both sides.
- Drops all contents on a branch-mispredict flush.
- Data is opaque to the block: packed PC plus instruction word plus predecode bits.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- WIDTH, 64, bits per entry.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous flush; empties the queue.
- prv_valid  input  1  upstream entry valid.
- prv_ready  output  1  queue can accept an entry this cycle.
- prv_data  input  WIDTH  upstream entry.
- nxt_valid  output  1  head entry valid.
- nxt_ready  input  1  downstream accepts the head entry.
- nxt_data  output  WIDTH  head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  high when count >= DEPTH-1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Head and tail pointers clear to 0; count clears to 0.
  - All storage entries clear to 0.
  - nxt_valid=0, nxt_data=0, prv_ready=1, almost_full=0.
  - Deasserting rst_n mid-operation resumes from the empty state. No partial state survives.
- Pointers:
  - head_ptr and tail_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
  - Indices wrap from DEPTH-1 to 0 with the MSB toggling.
- Outputs:
  - prv_ready = ~full. No same-cycle pop-through when full: a full queue refuses a push even if a pop occurs that cycle.
  - nxt_valid = ~empty.
  - nxt_data = storage[head_ptr low bits], driven combinationally from registered storage.
  - When empty, nxt_data shows the stale entry at head. Consumers must ignore it.
- Push: when prv_valid && prv_ready && ~flush, write prv_data to storage[tail], then advance tail by 1.
- Pop: when nxt_valid && nxt_ready && ~flush, advance head by 1.
- Simultaneous push and pop (non-full, non-empty): both occur and count is unchanged.
- Simultaneous push and pop at count==1: the old head pops, the new entry becomes head next cycle, and nxt_valid stays 1.
- Latency: an entry pushed at edge N is visible on nxt_data/nxt_valid after edge N. This gives 1-cycle minimum latency with no combinational path from prv_* to nxt_*.
- Flush (synchronous; priority over push and pop):
  - Next edge: head <= tail, count <= 0.
  - Push and pop in the flush cycle are ignored. prv_ready still follows ~full in that cycle.
  - After the flush edge: nxt_valid=0, prv_ready=1.
  - Storage contents are not cleared.
- count: registered, incremented on push only, decremented on pop only. It never exceeds DEPTH and never underflows.
- almost_full: combinational from count.
- Throughput: 1 push and 1 pop per cycle sustained when neither full nor empty.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> nxt_valid=0, prv_ready=1, count=0, almost_full=0, nxt_data=0.
- Fill/drain order (DEPTH=8): push 0x10..0x17 with nxt_ready=0 -> count reaches 8, prv_ready=0, almost_full=1 from count=7. Then set nxt_ready=1 -> pops return 0x10..0x17 in order over 8 cycles, finishing with count=0 and nxt_valid=0.
- Full refuses pop-through: at count=8, assert prv_valid=1 with data 0xAA and nxt_ready=1 -> one pop occurs, 0xAA is not accepted, count=7. On the next cycle 0xAA is accepted.
- Wrap-around streaming: push/pop concurrently for 20 cycles with data 0..19 -> count stays at its steady value and the output sequence equals 0..19, proving both pointers wrapped twice.
- Flush mid-stream: at count=5, assert flush=1 together with prv_valid=1 and nxt_ready=1 -> next cycle count=0, nxt_valid=0, and neither the flushed-cycle data nor any popped data is observed. The first push after the flush appears at head one cycle later.
- Async reset mid-operation: at count=4, drop rst_n between clock edges -> outputs go to reset values immediately, without waiting for an edge. After release, push 0x55 -> nxt_data=0x55 and count=1.
